// File: rtl/instr_mem_responder_pkg.sv
// Shared constants, instruction field positions and fetch-FSM state type
// for the instruction memory responder.
package instr_mem_responder_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam int OPCODE_MSB  = 7;
  localparam int OPCODE_LSB  = 4;
  localparam int OPERAND_MSB = 3;
  localparam int OPERAND_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/instr_mem_responder_mem_array.sv
// Register-file program storage: async clear, one write port,
// one combinational read port.
module instr_mem_responder_mem_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: req/valid handshake with optional wait
// states in front of a writable program memory.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_valid_o,
  output logic [DATA_W-1:0] fetch_instr_o,
  output logic              fetch_busy_o,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic              prog_err_o,
  output logic [7:0]        fetch_count_o
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, busy_q, err_q;
  logic [DATA_W-1:0] instr_q;
  logic [7:0]        count_q;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    mem_we  = prog_we_i && (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (fetch_req_i) begin
          addr_d = fetch_addr_i;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            wcnt_d  = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) state_d = RESP;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory is read at the RESP edge, so a same-cycle IDLE write is visible.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      busy_q  <= (state_d != IDLE);
      err_q   <= prog_we_i && (state_q != IDLE);
      valid_q <= (state_q == RESP);
      if (state_q == RESP) begin
        instr_q <= rd_data;
        count_q <= count_q + 8'd1;
      end
    end
  end

  instr_mem_responder_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (mem_we),
    .waddr_i (prog_addr_i),
    .wdata_i (prog_data_i),
    .raddr_i (addr_q),
    .rdata_o (rd_data)
  );

  assign fetch_valid_o = valid_q;
  assign fetch_instr_o = instr_q;
  assign fetch_busy_o  = busy_q;
  assign prog_err_o    = err_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: one instance with no wait states, one with
// three, checked against a transaction-level memory/counter model.
module tb_instr_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       req   [2];
  logic [3:0] faddr [2];
  logic       pwe   [2];
  logic [3:0] paddr [2];
  logic [7:0] pdata [2];
  logic       valid [2];
  logic [7:0] instr [2];
  logic       busy  [2];
  logic       err   [2];
  logic [7:0] cnt   [2];

  instr_mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .reset_i(rst[0]), .fetch_req_i(req[0]), .fetch_addr_i(faddr[0]),
    .fetch_valid_o(valid[0]), .fetch_instr_o(instr[0]), .fetch_busy_o(busy[0]),
    .prog_we_i(pwe[0]), .prog_addr_i(paddr[0]), .prog_data_i(pdata[0]),
    .prog_err_o(err[0]), .fetch_count_o(cnt[0])
  );

  instr_mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(3)) dut3 (
    .clk_i(clk), .reset_i(rst[1]), .fetch_req_i(req[1]), .fetch_addr_i(faddr[1]),
    .fetch_valid_o(valid[1]), .fetch_instr_o(instr[1]), .fetch_busy_o(busy[1]),
    .prog_we_i(pwe[1]), .prog_addr_i(paddr[1]), .prog_data_i(pdata[1]),
    .prog_err_o(err[1]), .fetch_count_o(cnt[1])
  );

  // Reference model: memory image and completed-response count per instance.
  logic [7:0] ref_mem [2][16];
  logic [7:0] ref_cnt [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] fa;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [6];

  function automatic int wc(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_ref(input int d);
    for (int i = 0; i < 16; i++) ref_mem[d][i] = 8'h00;
    ref_cnt[d] = 8'h00;
  endtask

  // Called at a negedge with the instance idle; returns at a negedge.
  task automatic do_write(input int d, input logic [3:0] a, input logic [7:0] v);
    pwe[d] = 1'b1; paddr[d] = a; pdata[d] = v;
    @(posedge clk); @(negedge clk);
    pwe[d] = 1'b0;
    chk("idle write err", err[d], 0);
    ref_mem[d][a] = v;
  endtask

  // Issues one fetch (optionally with a same-cycle write, and optionally a
  // write attempt while busy) and checks latency, data and count.
  // Returns at the negedge where fetch_valid is seen.
  task automatic do_fetch(input int d, input logic [3:0] fa, input logic we,
                          input logic [3:0] wa, input logic [7:0] wd,
                          input logic bw, input logic [3:0] bwa, input logic [7:0] bwd,
                          input logic use_exp, input logic [7:0] exp_in, input string nm);
    int k;
    logic [7:0] exp;
    req[d] = 1'b1; faddr[d] = fa;
    pwe[d] = we; paddr[d] = wa; pdata[d] = wd;
    if (we) ref_mem[d][wa] = wd;
    exp = use_exp ? exp_in : ref_mem[d][fa];
    @(posedge clk); @(negedge clk);
    req[d] = 1'b0; pwe[d] = 1'b0;
    if (bw) begin pwe[d] = 1'b1; paddr[d] = bwa; pdata[d] = bwd; end
    for (k = 0; k <= 40; k++) begin
      if (k == 1 && bw) begin
        chk({nm, " busy write err"}, err[d], 1);
        pwe[d] = 1'b0;
      end
      if (valid[d]) break;
      @(negedge clk);
    end
    chk({nm, " latency"}, k, wc(d) + 1);
    ref_cnt[d] = ref_cnt[d] + 8'd1;
    chk({nm, " instr"}, instr[d], exp);
    chk({nm, " count"}, cnt[d], ref_cnt[d]);
  endtask

  initial begin
    int t1, nbusy, vat;

    tbl[0] = '{1'b1, 4'd2,  8'h5E, 4'd2,  8'h5E};
    tbl[1] = '{1'b1, 4'd7,  8'h11, 4'd5,  8'hA7};
    tbl[2] = '{1'b0, 4'd0,  8'h00, 4'd7,  8'h11};
    tbl[3] = '{1'b1, 4'd15, 8'hC3, 4'd15, 8'hC3};
    tbl[4] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'h00};
    tbl[5] = '{1'b0, 4'd0,  8'h00, 4'd2,  8'h5E};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; faddr[d] = '0;
      pwe[d] = 1'b0; paddr[d] = '0; pdata[d] = '0;
      clr_ref(d);
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk("reset valid", valid[d], 0);
      chk("reset instr", instr[d], 0);
      chk("reset busy",  busy[d],  0);
      chk("reset err",   err[d],   0);
      chk("reset count", cnt[d],   0);
    end

    do_fetch(0, 4'd3, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 8'h00, "reset fetch 3");
    chk("first count", cnt[0], 1);

    do_write(0, 4'd5,  8'hA7);
    do_write(0, 4'd15, 8'h3C);
    do_fetch(0, 4'd5,  1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 8'hA7, "prog fetch 5");
    t1 = cyc;
    do_fetch(0, 4'd15, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 8'h3C, "prog fetch 15");
    chk("back-to-back spacing", cyc - t1, 2);

    for (int i = 0; i < 6; i++) begin
      do_fetch(0, tbl[i].fa, tbl[i].we, tbl[i].wa, tbl[i].wd, 1'b0, 4'd0, 8'h00,
               1'b1, tbl[i].exp, $sformatf("table %0d", i));
    end

    // Wait states, held request while busy, and a rejected write during WAIT.
    do_write(1, 4'd5, 8'hA7);
    req[1] = 1'b1; faddr[1] = 4'd5;
    @(posedge clk); @(negedge clk);
    nbusy = 0; vat = -1;
    for (int k = 0; k <= 5; k++) begin
      if (busy[1]) nbusy++;
      if (valid[1] && vat < 0) vat = k;
      if (k == 0) faddr[1] = 4'd9;
      if (k == 1) begin pwe[1] = 1'b1; paddr[1] = 4'd5; pdata[1] = 8'hFF; end
      if (k == 2) begin chk("collision err pulse", err[1], 1); pwe[1] = 1'b0; end
      if (k == 3) begin chk("collision err end", err[1], 0); req[1] = 1'b0; end
      if (k == 4) chk("wait-state instr", instr[1], 8'hA7);
      if (k == 5) begin
        chk("held req ignored valid", valid[1], 0);
        chk("held req ignored busy", busy[1], 0);
      end
      if (k < 5) @(negedge clk);
    end
    chk("busy cycles", nbusy, 4);
    chk("wait-state valid cycle", vat, 4);
    ref_cnt[1] = ref_cnt[1] + 8'd1;
    chk("wait-state count", cnt[1], ref_cnt[1]);
    do_fetch(1, 4'd5, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 8'hA7, "after collision 5");

    for (int i = 0; i < 60; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      do_fetch(d, 4'($urandom), ($urandom % 3) == 0, 4'($urandom), 8'($urandom),
               ($urandom % 4) == 0, 4'($urandom), 8'($urandom), 1'b0, 8'h00,
               $sformatf("random %0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while valid is high must clear it without a clock edge.
    do_fetch(0, 4'd2, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, "pre-reset fetch");
    rst[0] = 1'b1;
    #1;
    chk("async reset valid", valid[0], 0);
    chk("async reset count", cnt[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    clr_ref(0);

    for (int i = 0; i < 256; i++) begin
      do_fetch(0, 4'($urandom), ($urandom % 4) == 0, 4'($urandom), 8'($urandom),
               1'b0, 4'd0, 8'h00, 1'b0, 8'h00, $sformatf("wrap %0d", i));
      if (i == 254) chk("count at 255", cnt[0], 255);
    end
    chk("count wrapped", cnt[0], 0);

    // Reset during WAIT.
    @(negedge clk);
    req[1] = 1'b1; faddr[1] = 4'd5;
    @(posedge clk); @(negedge clk);
    req[1] = 1'b0;
    chk("mid-op busy before reset", busy[1], 1);
    rst[1] = 1'b1;
    #1;
    chk("mid-op reset busy", busy[1], 0);
    chk("mid-op reset valid", valid[1], 0);
    @(negedge clk);
    rst[1] = 1'b0;
    clr_ref(1);
    repeat (5) @(negedge clk);
    chk("no stale response after reset", valid[1], 0);
    do_fetch(1, 4'd5, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 8'h00, "post-reset fetch 5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
